// File: rtl/pe_pkg.sv
// Shared types and arithmetic helpers for the PE output paths.
//   tag_t      : {valid, last} tag that travels alongside the dot-product tree
//   sat_signed : clamp a signed value to a signed range of a given width
//   requant    : round-half-up arithmetic right shift, then optional ReLU
package pe_pkg;

    typedef struct packed {
        logic valid;
        logic last;
    } tag_t;

    // Clamp to [-2^(width-1), 2^(width-1)-1]. Values are carried at 64 bits so
    // the same helper serves every accumulator and output width up to 63.
    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                      input int                 width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (value > hi) return hi;
        if (value < lo) return lo;
        return value;
    endfunction

    // The 64-bit working width is wide enough that adding the rounding
    // constant to any accumulator up to 62 bits cannot overflow.
    function automatic logic signed [63:0] requant(input logic signed [63:0] acc,
                                                   input logic [4:0]         shift,
                                                   input logic               relu);
        logic signed [63:0] r;
        r = acc;
        if (shift != 5'd0) r = r + (64'sd1 <<< (shift - 5'd1));
        r = r >>> shift;
        if (relu && (r < 64'sd0)) r = 64'sd0;
        return r;
    endfunction

endpackage

// File: rtl/pe_out_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
//   push/push_data : write one entry (must not be asserted while full)
//   pop            : consume the head entry; ignored when empty
//   pop_data       : head entry, valid whenever !empty
//   empty, count   : occupancy status (count is 0..DEPTH)
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module pe_out_fifo #(
    parameter int  W     = 8,
    parameter int  DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         empty,
    output logic [AW:0]  count
);

    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];
    logic [AW:0]  wr_q, wr_d;
    logic [AW:0]  rd_q, rd_d;
    logic         full;

    assign count    = wr_q - rd_q;
    assign empty    = (wr_q == rd_q);
    assign full     = (count == (AW + 1)'(DEPTH));
    assign pop_data = mem_q[rd_q[AW-1:0]];

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (push) begin
            mem_d[wr_q[AW-1:0]] = push_data;
            wr_d                = wr_q + PTR_ONE;
        end
        if (pop && !empty) begin
            rd_d = rd_q + PTR_ONE;
        end
    end

    // Storage is cleared on reset so the head output reads 0 out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '{default: '0};
            wr_q  <= '0;
            rd_q  <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/vec_acc_requant.sv
// Accumulate / requantize stage behind the dot-product tree.
//   issue_valid/issue_last/issue_ready : feeder beat handshake and credit
//   y                                  : tree output, LAT cycles after issue
//   bias/cfg_shift/cfg_relu            : per-group settings, sampled when the
//                                        matching tree result arrives
//   m_data/m_valid/m_ready             : output FIFO master port
// The tree carries no valid, so a {valid,last} tag is delayed LAT cycles to
// line up with y. Credits bound in-flight groups so the FIFO never overflows.
module vec_acc_requant
    import pe_pkg::*;
#(
    parameter int  C          = 8,
    parameter int  W_X        = 8,
    parameter int  W_K        = 8,
    parameter int  W_ACC      = 32,
    parameter int  W_OUT      = 8,
    parameter int  FIFO_DEPTH = 4,
    localparam int W_Y        = W_X + W_K + $clog2(C)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    issue_valid,
    input  logic                    issue_last,
    output logic                    issue_ready,
    input  logic signed [W_Y-1:0]   y,
    input  logic signed [W_ACC-1:0] bias,
    input  logic [4:0]              cfg_shift,
    input  logic                    cfg_relu,
    output logic signed [W_OUT-1:0] m_data,
    output logic                    m_valid,
    input  logic                    m_ready
);

    localparam int LAT    = $clog2(C) + 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int PEND_W = $clog2(LAT + FIFO_DEPTH + 1);

    tag_t [LAT:1]            tag_pipe_q, tag_pipe_d;
    tag_t                    tag_in, tag_al;
    logic signed [W_ACC-1:0] acc_q, acc_d;
    logic                    first_q, first_d;
    logic signed [W_ACC-1:0] base, acc_next;
    logic signed [W_ACC:0]   sum;
    logic [PEND_W-1:0]       pend;
    logic                    push, pop, fifo_empty;
    logic [W_OUT-1:0]        push_data;
    logic [CNT_W-1:0]        fifo_count;

    // Outstanding groups = last-tags still in the pipe + results in the FIFO.
    // Only registered state feeds this, so issue_ready has no input paths.
    always_comb begin
        pend = PEND_W'(fifo_count);
        for (int i = 1; i <= LAT; i++) begin
            pend = pend + PEND_W'(tag_pipe_q[i].last);
        end
    end

    assign issue_ready = (pend < PEND_W'(FIFO_DEPTH));
    assign m_valid     = !fifo_empty;
    assign pop         = m_valid && m_ready;

    always_comb begin
        // A refused beat is not tagged; the feeder retries it.
        tag_in.valid  = issue_valid && issue_ready;
        tag_in.last   = issue_valid && issue_ready && issue_last;
        tag_pipe_d[1] = tag_in;
        for (int i = 2; i <= LAT; i++) begin
            tag_pipe_d[i] = tag_pipe_q[i-1];
        end
        tag_al = tag_pipe_q[LAT];

        // first_q selects bias, so a new group never inherits the old sum.
        base      = first_q ? bias : acc_q;
        sum       = (W_ACC + 1)'(base) + (W_ACC + 1)'(y);
        acc_next  = W_ACC'(sat_signed(64'(sum), W_ACC));
        push      = tag_al.valid && tag_al.last;
        push_data = W_OUT'(sat_signed(requant(64'(acc_next), cfg_shift, cfg_relu), W_OUT));

        acc_d   = acc_q;
        first_d = first_q;
        if (tag_al.valid) begin
            acc_d   = acc_next;
            first_d = tag_al.last;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_pipe_q <= '0;
            acc_q      <= '0;
            first_q    <= 1'b1;
        end else begin
            tag_pipe_q <= tag_pipe_d;
            acc_q      <= acc_d;
            first_q    <= first_d;
        end
    end

    pe_out_fifo #(
        .W     (W_OUT),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (m_data),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_vec_acc_requant.sv
module tb_vec_acc_requant;

    localparam int C     = 8;
    localparam int W_X   = 8;
    localparam int W_K   = 8;
    localparam int W_Y   = W_X + W_K + $clog2(C);
    localparam int W_ACC = 32;
    localparam int W_OUT = 8;
    localparam int DEPTH = 4;
    localparam int LAT   = $clog2(C) + 1;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    issue_valid, issue_last, issue_ready;
    logic signed [W_Y-1:0]   y;
    logic signed [W_ACC-1:0] bias;
    logic [4:0]              cfg_shift;
    logic                    cfg_relu;
    logic signed [W_OUT-1:0] m_data;
    logic                    m_valid, m_ready;

    // Feeder-side values for the beat in the current cycle; the tree model
    // delays them LAT cycles so they arrive together with the tree result.
    logic signed [W_Y-1:0]   beat_y;
    logic signed [W_ACC-1:0] beat_bias;
    logic [4:0]              beat_shift;
    logic                    beat_relu;
    logic signed [W_Y-1:0]   dl_y     [1:LAT];
    logic signed [W_ACC-1:0] dl_bias  [1:LAT];
    logic [4:0]              dl_shift [1:LAT];
    logic                    dl_relu  [1:LAT];

    int     total = 0;
    int     bad   = 0;
    int     exp_q[$];
    longint m_acc;
    bit     m_first;

    vec_acc_requant #(
        .C(C), .W_X(W_X), .W_K(W_K), .W_ACC(W_ACC), .W_OUT(W_OUT), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_last(issue_last),
        .issue_ready(issue_ready), .y(y), .bias(bias), .cfg_shift(cfg_shift),
        .cfg_relu(cfg_relu), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        dl_y[1]     <= beat_y;
        dl_bias[1]  <= beat_bias;
        dl_shift[1] <= beat_shift;
        dl_relu[1]  <= beat_relu;
        for (int i = 2; i <= LAT; i++) begin
            dl_y[i]     <= dl_y[i-1];
            dl_bias[i]  <= dl_bias[i-1];
            dl_shift[i] <= dl_shift[i-1];
            dl_relu[i]  <= dl_relu[i-1];
        end
    end

    assign y         = dl_y[LAT];
    assign bias      = dl_bias[LAT];
    assign cfg_shift = dl_shift[LAT];
    assign cfg_relu  = dl_relu[LAT];

    // Reference arithmetic on plain 64-bit integers.
    function automatic longint ref_sat(input longint v, input int w);
        longint hi, lo;
        hi = (longint'(1) <<< (w - 1)) - 1;
        lo = -(longint'(1) <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic int ref_out(input longint a, input int sh, input bit rl);
        longint r;
        r = a;
        if (sh > 0) r = r + (longint'(1) <<< (sh - 1));
        r = r >>> sh;
        if (rl && r < 0) r = 0;
        return int'(ref_sat(r, W_OUT));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat for one cycle; the model follows only accepted beats.
    task automatic send(input int yv, input bit last, input longint b, input int sh,
                        input bit rl, output bit acc);
        longint base;
        issue_valid = 1'b1;
        issue_last  = last;
        beat_y      = W_Y'(yv);
        beat_bias   = W_ACC'(b);
        beat_shift  = 5'(sh);
        beat_relu   = rl;
        acc         = issue_ready;
        if (acc) begin
            base    = m_first ? b : m_acc;
            m_acc   = ref_sat(base + longint'(yv), W_ACC);
            m_first = last;
            if (last) exp_q.push_back(ref_out(m_acc, sh, rl));
        end
        tick();
        issue_valid = 1'b0;
        issue_last  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (m_valid !== 1'b0)     begin bad++; $display("FAIL reset_m_valid got=%0b exp=0", m_valid); end
        total++; if (m_data !== '0)        begin bad++; $display("FAIL reset_m_data got=%0d exp=0", m_data); end
        total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL reset_issue_ready got=%0b exp=1", issue_ready); end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_latency();
        int yv;
        bit acc, ev;
        yv = 0;
        for (int i = 0; i < C; i++) yv += 1 * 2;
        m_ready = 1'b1;
        send(yv, 1'b1, 0, 0, 1'b0, acc);
        for (int k = 1; k <= LAT + 3; k++) begin
            @(negedge clk);
            ev = (k == LAT + 1);
            total++; if (m_valid !== ev) begin bad++; $display("FAIL single_valid k=%0d got=%0b exp=%0b", k, m_valid, ev); end
            if (ev && exp_q.size() > 0) begin
                total++; if ($signed(m_data) !== exp_q[0]) begin bad++; $display("FAIL single_data got=%0d exp=%0d", $signed(m_data), exp_q[0]); end
                void'(exp_q.pop_front());
            end
            tick();
        end
    endtask

    task automatic test_multi_beat();
        bit acc;
        int got, e;
        m_ready = 1'b1;
        got     = 0;
        send(100, 1'b0, -50, 2, 1'b0, acc);
        send(100, 1'b0, -50, 2, 1'b0, acc);
        send(100, 1'b1, -50, 2, 1'b0, acc);
        for (int k = 0; k < LAT + 4; k++) begin
            @(negedge clk);
            if (m_valid) begin
                got++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 9999;
                total++; if ($signed(m_data) !== e) begin bad++; $display("FAIL multi_data got=%0d exp=%0d", $signed(m_data), e); end
            end
            tick();
        end
        total++; if (got !== 1) begin bad++; $display("FAIL multi_count got=%0d exp=1", got); end
    endtask

    task automatic test_clamp();
        longint cb[5] = '{0, 0, 0, 64'sd2147483647, -64'sd2147483648};
        int     cy[5] = '{-1000, -1000, 1000, 1000, -1000};
        int     cn[5] = '{1, 1, 1, 2, 1};
        int     cs[5] = '{0, 0, 0, 31, 31};
        bit     cr[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        bit     acc;
        int     got, e;
        m_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            got = 0;
            for (int b = 0; b < cn[c]; b++) send(cy[c], (b == cn[c] - 1), cb[c], cs[c], cr[c], acc);
            for (int k = 0; k < LAT + 3; k++) begin
                @(negedge clk);
                if (m_valid) begin
                    got++;
                    e = (exp_q.size() > 0) ? exp_q.pop_front() : 9999;
                    total++; if ($signed(m_data) !== e) begin bad++; $display("FAIL clamp%0d_data got=%0d exp=%0d", c, $signed(m_data), e); end
                end
                tick();
            end
            total++; if (got !== 1) begin bad++; $display("FAIL clamp%0d_count got=%0d exp=1", c, got); end
        end
    endtask

    task automatic test_back_to_back();
        bit acc, ev;
        m_ready = 1'b1;
        send(10, 1'b1, 1, 0, 1'b0, acc);
        send(20, 1'b1, 2, 0, 1'b0, acc);
        for (int k = 2; k <= LAT + 4; k++) begin
            @(negedge clk);
            ev = (k == LAT + 1) || (k == LAT + 2);
            total++; if (m_valid !== ev) begin bad++; $display("FAIL b2b_valid k=%0d got=%0b exp=%0b", k, m_valid, ev); end
            if (ev && exp_q.size() > 0) begin
                total++; if ($signed(m_data) !== exp_q[0]) begin bad++; $display("FAIL b2b_data got=%0d exp=%0d", $signed(m_data), exp_q[0]); end
                void'(exp_q.pop_front());
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        bit acc;
        int got, e;
        m_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            send(10 * (i + 1), 1'b1, 0, 0, 1'b0, acc);
            total++; if (acc !== 1'b1) begin bad++; $display("FAIL bp_accept%0d got=%0b exp=1", i, acc); end
        end
        total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_low got=%0b exp=0", issue_ready); end
        send(50, 1'b1, 0, 0, 1'b0, acc);
        total++; if (acc !== 1'b0) begin bad++; $display("FAIL bp_fifth_tagged got=%0b exp=0", acc); end
        repeat (LAT + 2) tick();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid got=%0b exp=1", m_valid); end
            total++; if ($signed(m_data) !== exp_q[0]) begin bad++; $display("FAIL bp_hold_data got=%0d exp=%0d", $signed(m_data), exp_q[0]); end
            total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL bp_full_ready got=%0b exp=0", issue_ready); end
            tick();
        end
        m_ready = 1'b1;
        @(negedge clk);
        e = exp_q.pop_front();
        total++; if ($signed(m_data) !== e) begin bad++; $display("FAIL bp_pop_data got=%0d exp=%0d", $signed(m_data), e); end
        tick();
        m_ready = 1'b0;
        total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_after_pop got=%0b exp=1", issue_ready); end
        m_ready = 1'b1;
        got     = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (m_valid) begin
                got++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 9999;
                total++; if ($signed(m_data) !== e) begin bad++; $display("FAIL bp_order got=%0d exp=%0d", $signed(m_data), e); end
            end
            tick();
        end
        total++; if (got !== DEPTH - 1) begin bad++; $display("FAIL bp_drain_count got=%0d exp=%0d", got, DEPTH - 1); end
    endtask

    task automatic test_reset_mid_group();
        bit acc;
        int got, e;
        m_ready = 1'b1;
        send(7, 1'b0, 100, 0, 1'b0, acc);
        send(9, 1'b0, 100, 0, 1'b0, acc);
        rst = 1'b1;
        @(negedge clk);
        total++; if (m_valid !== 1'b0)     begin bad++; $display("FAIL midrst_valid got=%0b exp=0", m_valid); end
        total++; if (m_data !== '0)        begin bad++; $display("FAIL midrst_data got=%0d exp=0", m_data); end
        total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%0b exp=1", issue_ready); end
        tick();
        rst     = 1'b0;
        m_first = 1'b1;
        m_acc   = 0;
        exp_q.delete();
        tick();
        send(3, 1'b1, 5, 0, 1'b0, acc);
        got = 0;
        for (int k = 0; k < LAT + 6; k++) begin
            @(negedge clk);
            if (m_valid) begin
                got++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 9999;
                total++; if ($signed(m_data) !== e) begin bad++; $display("FAIL midrst_result got=%0d exp=%0d", $signed(m_data), e); end
            end
            tick();
        end
        total++; if (got !== 1) begin bad++; $display("FAIL midrst_count got=%0d exp=1", got); end
    endtask

    task automatic test_random();
        localparam int NG = 40;
        int got, cyc, e;
        got = 0;
        cyc = 0;
        fork
            begin
                int     nb, sh, yv;
                bit     rl, acc;
                longint b;
                for (int g = 0; g < NG; g++) begin
                    nb = $urandom_range(1, 4);
                    if ($urandom_range(0, 3) == 0) b = longint'(int'($urandom()));
                    else                          b = longint'(int'($urandom_range(0, 2000))) - 1000;
                    sh = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 12));
                    rl = 1'($urandom_range(0, 1));
                    for (int i = 0; i < nb; i++) begin
                        yv = int'($urandom_range(0, (1 << W_Y) - 1)) - (1 << (W_Y - 1));
                        do send(yv, (i == nb - 1), b, sh, rl, acc); while (!acc);
                        if ($urandom_range(0, 3) == 0) tick();
                    end
                end
            end
            begin
                while (got < NG && cyc < 4000) begin
                    m_ready = 1'($urandom_range(0, 1));
                    @(negedge clk);
                    if (m_valid && m_ready) begin
                        got++;
                        e = (exp_q.size() > 0) ? exp_q.pop_front() : 9999;
                        total++; if ($signed(m_data) !== e) begin bad++; $display("FAIL rand_data n=%0d got=%0d exp=%0d", got, $signed(m_data), e); end
                    end
                    cyc++;
                    tick();
                end
            end
        join
        m_ready = 1'b0;
        total++; if (got !== NG) begin bad++; $display("FAIL rand_count got=%0d exp=%0d", got, NG); end
        total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL rand_leftover got=%0d exp=0", exp_q.size()); end
    endtask

    initial begin
        rst         = 1'b1;
        issue_valid = 1'b0;
        issue_last  = 1'b0;
        m_ready     = 1'b0;
        beat_y      = '0;
        beat_bias   = '0;
        beat_shift  = '0;
        beat_relu   = 1'b0;
        m_first     = 1'b1;
        m_acc       = 0;
        test_reset();
        test_single_latency();
        test_multi_beat();
        test_clamp();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_group();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
